sr_input_conditioner: RTL and testbench

SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

---
 rtl/sr_input_conditioner.sv | 219 +++++++++++++++++++++
 tb/tb_sr_input_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// sr_input_conditioner
//
// Purpose:
//   Turns two raw, bouncing push buttons (set / clear) into clean, timed
//   command pulses for a downstream SR latch. Each button is synchronized,
//   debounced and edge-detected. A small FSM then turns each accepted request
//   into a fixed-length s/en or r/en pulse, followed by a hold-off gap.
//
// Handshake / interface semantics:
//   There is no valid/ready pair on this block. Each debounced rising edge is
//   a one-cycle request. The FSM takes a request only while it is IDLE.
//   Requests that arrive while it is busy are dropped and are not queued.
//   If both requests arrive in the same cycle, both are rejected and conflict
//   pulses for one cycle.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous, active-high clear of all state
//   set_btn    in   1  raw set push button (asynchronous, may bounce)
//   clr_btn    in   1  raw clear push button (asynchronous, may bounce)
//   s          out  1  registered set drive (only with en)
//   r          out  1  registered reset drive (only with en)
//   en         out  1  registered latch enable
//   busy       out  1  registered, high whenever the FSM is not IDLE
//   conflict   out  1  registered one-cycle pulse on a rejected set+clear
//   cmd_count  out  8  registered count of issued commands, wraps 255 -> 0
//
// Parameters (legal 1..255):
//   DB_CYCLES  consecutive mismatch cycles before a debounced level toggles
//   PULSE_LEN  cycles s or r is held with en per command
//   HOLDOFF    idle cycles after each pulse before a new command is taken
//
// The FSM state is held in the internal signal 'state' (type state_t).
// Checkers can bind to that name.
// -----------------------------------------------------------------------------
module sr_input_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned HOLDOFF   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_btn,
    input  logic       clr_btn,
    output logic       s,
    output logic       r,
    output logic       en,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] cmd_count
);

    // Terminal values for the 8-bit counters. Each counter counts from 0, so
    // the last cycle of an N-cycle interval is seen at count N-1.
    localparam logic [7:0] DB_LAST    = 8'(DB_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF - 1);

    // Index 0 = set button, index 1 = clear button.
    localparam int SET_IDX = 0;
    localparam int CLR_IDX = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE_SET = 2'd1,
        DRIVE_CLR = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer, debouncer, rising-edge detect
    // -------------------------------------------------------------------------
    logic [1:0] sync_meta;     // first synchronizer stage (may go metastable)
    logic [1:0] sync_q;        // second synchronizer stage (safe to use)
    logic [1:0] level;         // debounced level
    logic [1:0] level_d;       // delayed copy of level for edge detection
    logic [7:0] db_cnt [2];    // per-button mismatch run length
    logic [1:0] req;           // one-cycle request pulses

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 2'b00;
            sync_q    <= 2'b00;
            level     <= 2'b00;
            level_d   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            // The raw buttons are used here and nowhere else.
            sync_meta <= {clr_btn, set_btn};
            sync_q    <= sync_meta;
            level_d   <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != level[i]) begin
                    // The run length includes the current mismatch cycle. So
                    // the level toggles on the DB_CYCLES-th consecutive
                    // mismatch, and the count restarts on the same edge.
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= ~level[i];
                        db_cnt[i] <= 8'd0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    // Any agreement means the input was bouncing, so start over.
                    db_cnt[i] <= 8'd0;
                end
            end
        end
    end

    // A request is a press only. A debounced release generates nothing.
    assign req = level & ~level_d;

    logic set_req;
    logic clr_req;
    assign set_req = req[SET_IDX];
    assign clr_req = req[CLR_IDX];

    // -------------------------------------------------------------------------
    // Command FSM: state register
    // -------------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [7:0] phase;           // cycles spent in the current DRIVE_*/HOLD
    logic [7:0] phase_next;
    logic       conflict_next;
    logic [7:0] count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= 8'd0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // -------------------------------------------------------------------------
    // Command FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        phase_next    = phase;
        conflict_next = 1'b0;
        count_next    = cmd_count;

        case (state)
            IDLE: begin
                phase_next = 8'd0;
                if (set_req && clr_req) begin
                    // An ambiguous command is rejected. Nothing is issued or
                    // counted.
                    conflict_next = 1'b1;
                end else if (set_req) begin
                    state_next = DRIVE_SET;
                    count_next = cmd_count + 8'd1;
                end else if (clr_req) begin
                    state_next = DRIVE_CLR;
                    count_next = cmd_count + 8'd1;
                end
            end

            DRIVE_SET, DRIVE_CLR: begin
                if (phase == PULSE_LAST) begin
                    state_next = HOLD;
                    phase_next = 8'd0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end

            HOLD: begin
                // Requests that pulse during this state are dropped here.
                // Only IDLE looks at req.
                if (phase == HOLD_LAST) begin
                    state_next = IDLE;
                    phase_next = 8'd0;
                end else begin
                    phase_next = phase + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                phase_next = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    // The outputs are decoded from state_next. This lets them change on the
    // same edge that enters the state, while still coming straight from flops.
    // s and r each decode a single distinct state, so they can never both be
    // 1. Each of them implies en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s         <= 1'b0;
            r         <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            conflict  <= 1'b0;
            cmd_count <= 8'd0;
        end else begin
            s         <= (state_next == DRIVE_SET);
            r         <= (state_next == DRIVE_CLR);
            en        <= (state_next == DRIVE_SET) || (state_next == DRIVE_CLR);
            busy      <= (state_next != IDLE);
            conflict  <= conflict_next;
            cmd_count <= count_next;
        end
    end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sr_input_conditioner
//
// Directed bench for sr_input_conditioner with DB_CYCLES=4, PULSE_LEN=2 and
// HOLDOFF=4. Edge numbers in the comments count rising clock edges. Edge 1 is
// the first edge that samples a newly driven button level.
//
// Timing assumed for a clean press first sampled at edge 1:
//   edge 2  : synchronizer output goes high
//   edge 6  : debounced level rises (4 consecutive mismatch cycles, edges 3-6)
//   edge 7  : FSM enters DRIVE, so s/en go high
//   edge 9  : FSM enters HOLD, so s/en go low
//   edge 13 : FSM returns to IDLE, so busy goes low
// -----------------------------------------------------------------------------
module tb_sr_input_conditioner;

    logic       clk;
    logic       reset;
    logic       set_btn;
    logic       clr_btn;
    logic       s;
    logic       r;
    logic       en;
    logic       busy;
    logic       conflict;
    logic [7:0] cmd_count;

    int n_vec;
    int n_err;

    sr_input_conditioner #(
        .DB_CYCLES (4),
        .PULSE_LEN (2),
        .HOLDOFF   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set_btn   (set_btn),
        .clr_btn   (clr_btn),
        .s         (s),
        .r         (r),
        .en        (en),
        .busy      (busy),
        .conflict  (conflict),
        .cmd_count (cmd_count)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // --------------------------------------------------------------- helpers
    // Advance one rising edge, then settle 1 time unit past it. This point is
    // used both to sample outputs and to drive new inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset across two edges with the buttons low. Check the cleared
    // outputs, then release reset. The next edge is edge 1 of the test.
    task automatic do_reset();
        reset   = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        step();
        step();
        check("rst_en",    8'(en),    8'd0);
        check("rst_count", cmd_count, 8'd0);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;

        // ---- Reset state
        step();
        step();
        check("reset_s",        8'(s),        8'd0);
        check("reset_r",        8'(r),        8'd0);
        check("reset_en",       8'(en),       8'd0);
        check("reset_busy",     8'(busy),     8'd0);
        check("reset_conflict", 8'(conflict), 8'd0);
        check("reset_count",    cmd_count,    8'd0);

        // ---- Clean set press: s/en after edges 7,8; busy through edge 12
        do_reset();
        set_btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            check($sformatf("set_s_e%0d", e),    8'(s),    8'((e == 7) || (e == 8)));
            check($sformatf("set_en_e%0d", e),   8'(en),   8'((e == 7) || (e == 8)));
            check($sformatf("set_r_e%0d", e),    8'(r),    8'd0);
            check($sformatf("set_busy_e%0d", e), 8'(busy), 8'((e >= 7) && (e <= 12)));
        end
        check("set_count", cmd_count, 8'd1);
        // A release must not produce a command.
        set_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("rel_en_e%0d", e), 8'(en), 8'd0);
        end
        check("rel_count", cmd_count, 8'd1);

        // ---- Bouncing clear button never settles: no output activity
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            clr_btn = (e % 2 == 1);
            step();
            check($sformatf("bnc_en_e%0d", e), 8'(en), 8'd0);
            check($sformatf("bnc_r_e%0d", e),  8'(r),  8'd0);
        end
        clr_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("bnc_tail_en_e%0d", e), 8'(en), 8'd0);
        end
        check("bnc_count", cmd_count, 8'd0);

        // ---- Simultaneous set and clear: conflict after edge 7 only
        do_reset();
        set_btn = 1'b1;
        clr_btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            check($sformatf("cf_conflict_e%0d", e), 8'(conflict), 8'(e == 7));
            check($sformatf("cf_en_e%0d", e),       8'(en),       8'd0);
            check($sformatf("cf_busy_e%0d", e),     8'(busy),     8'd0);
        end
        check("cf_count", cmd_count, 8'd0);

        // ---- Clear press whose request lands during HOLD is dropped
        do_reset();
        set_btn = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            // The clear button is first sampled at edge 4. Its request pulses
            // after edge 9, while the FSM is in HOLD.
            if (e == 4) clr_btn = 1'b1;
            step();
            check($sformatf("hd_s_e%0d", e),        8'(s),        8'((e == 7) || (e == 8)));
            check($sformatf("hd_r_e%0d", e),        8'(r),        8'd0);
            check($sformatf("hd_conflict_e%0d", e), 8'(conflict), 8'd0);
        end
        check("hd_count1", cmd_count, 8'd1);
        set_btn = 1'b0;
        clr_btn = 1'b0;
        for (int e = 1; e <= 10; e++) step();
        check("hd_idle_busy", 8'(busy), 8'd0);
        // A fresh clear press, with the FSM idle, is accepted.
        clr_btn = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("clr_r_e%0d", e),  8'(r),  8'((e == 7) || (e == 8)));
            check($sformatf("clr_en_e%0d", e), 8'(en), 8'((e == 7) || (e == 8)));
            check($sformatf("clr_s_e%0d", e),  8'(s),  8'd0);
        end
        check("clr_count2", cmd_count, 8'd2);
        clr_btn = 1'b0;
        for (int e = 1; e <= 10; e++) step();

        // ---- Reset mid-pulse clears everything asynchronously
        do_reset();
        set_btn = 1'b1;
        for (int e = 1; e <= 7; e++) step();
        check("mid_en_before", 8'(en), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        // These are sampled well before the next rising edge.
        check("mid_en",    8'(en),    8'd0);
        check("mid_s",     8'(s),     8'd0);
        check("mid_busy",  8'(busy),  8'd0);
        check("mid_count", cmd_count, 8'd0);
        // set_btn stays high through reset and is debounced again after
        // release.
        step();
        step();
        check("hold_rst_en", 8'(en), 8'd0);
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            check($sformatf("post_rst_en_e%0d", e), 8'(en), 8'((e == 7) || (e == 8)));
        end
        check("post_rst_count", cmd_count, 8'd1);
        set_btn = 1'b0;
        for (int e = 1; e <= 10; e++) step();

        // ---- 256 commands from reset: cmd_count wraps to 0
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            set_btn = 1'b1;
            for (int e = 1; e <= 8; e++) step();
            // The wait for the command to finish is bounded.
            for (int t = 0; t < 20 && busy; t++) step();
            if (k == 1 || k == 255 || k == 256) begin
                check($sformatf("wrap_busy_k%0d", k), 8'(busy), 8'd0);
            end
            set_btn = 1'b0;
            for (int e = 1; e <= 8; e++) step();
            if (k == 1)   check("wrap_count_1",   cmd_count, 8'd1);
            if (k == 128) check("wrap_count_128", cmd_count, 8'd128);
            if (k == 255) check("wrap_count_255", cmd_count, 8'd255);
            if (k == 256) check("wrap_count_256", cmd_count, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
